// File: rtl/capi_reset_seq.sv
// Ordered reset sequencer: holds every downstream domain in reset, then releases domains
// 0..NDOM-1 one at a time, waiting on each domain's ready (with optional timeout).
module capi_reset_seq #(
  parameter int unsigned NDOM     = 3,
  parameter int unsigned NREQ     = 2,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic [NDOM-1:0] i_ready,
  output logic [NDOM-1:0] o_reset,
  output logic            o_busy,
  output logic            o_done,
  output logic [NDOM-1:0] o_to_err
);

  localparam int unsigned KW = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] WaitLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [KW-1:0] DomLast  = KW'(NDOM - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StRelease,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   dom_q, dom_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [NDOM-1:0] to_err_d;
  logic [NDOM-1:0] reset_d;
  logic            busy_d;
  logic            done_d;
  logic            adv;

  always_comb begin
    state_d  = state_q;
    dom_d    = dom_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    to_err_d = o_to_err;
    adv      = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StAssert: begin
        if (hold_q == HoldLast) begin
          state_d = StRelease;
          dom_d   = '0;
          wait_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      StRelease: begin
        if (i_ready[dom_q]) begin
          adv = 1'b1;
        end else if ((TIMEOUT != 0) && (wait_q == WaitLast)) begin
          adv             = 1'b1;
          to_err_d[dom_q] = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
        if (adv) begin
          if (dom_q == DomLast) begin
            state_d = StDone;
          end else begin
            dom_d  = dom_q + KW'(1);
            wait_d = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A request anywhere restarts the whole sequence, including from DONE.
    if (|i_req) begin
      state_d  = StAssert;
      hold_d   = '0;
      wait_d   = '0;
      dom_d    = '0;
      to_err_d = '0;
    end

    // Outputs are decoded from the next state so they land in flops with one cycle latency.
    reset_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      StIdle: begin
        reset_d = '0;
      end
      StAssert: begin
        reset_d = '1;
        busy_d  = 1'b1;
      end
      StRelease: begin
        busy_d = 1'b1;
        for (int j = 0; j < int'(NDOM); j++) begin
          reset_d[j] = (j > int'(dom_d));
        end
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        reset_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StAssert;
      dom_q    <= '0;
      hold_q   <= '0;
      wait_q   <= '0;
      o_reset  <= '1;
      o_busy   <= 1'b1;
      o_done   <= 1'b0;
      o_to_err <= '0;
    end else begin
      state_q  <= state_d;
      dom_q    <= dom_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      o_reset  <= reset_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_to_err <= to_err_d;
    end
  end

endmodule
